sap_control_sequencer: RTL and testbench

Microcode sequencer for the SAP-U datapath. It steps through fetch and execute T-states and decodes the 4-bit opcode from the instruction register into the active-low/active-high control word. That control word drives the ALU (`eo_n` to its bus enable, `su` to subtract, `fi_n` to its flag load). It consumes the ALU's registered carry/zero flags to resolve conditional jumps. The sequencer is the control-side counterpart of the ALU and flag register: it issues the ALU's controls and reads back its flags.

---
 rtl/sap_control_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_sap_control_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/sap_control_sequencer.sv
// SAP-U microcode sequencer: T-state counter, halt latch and opcode decode into the control word.
// Optional build macro SEQ_EARLY_RESET_EN: step counter returns to T0 right after an instruction's last active step.
module sap_control_sequencer #(
    parameter int unsigned NUM_STEPS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [1:0] flags,
    output logic [2:0] step,
    output logic       halted,
    output logic       hlt,
    output logic       mi_n,
    output logic       ri_n,
    output logic       ro_n,
    output logic       io_n,
    output logic       ii_n,
    output logic       ai_n,
    output logic       ao_n,
    output logic       eo_n,
    output logic       bi_n,
    output logic       oi_n,
    output logic       co_n,
    output logic       j_n,
    output logic       fi_n,
    output logic       su,
    output logic       ce
);

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] LAST_STEP = 3'(NUM_STEPS - 1);

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_LDA = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_STA = 4'b0100;
    localparam logic [3:0] OP_LDI = 4'b0101;
    localparam logic [3:0] OP_JMP = 4'b0110;
    localparam logic [3:0] OP_JC  = 4'b0111;
    localparam logic [3:0] OP_JZ  = 4'b1000;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    logic [2:0] step_q;
    logic       halted_q;
    logic [2:0] last_step;
    logic       hlt_exec;

    assign step     = step_q;
    assign halted   = halted_q;
    assign hlt_exec = !halted_q && (step_q == T2) && (opcode == OP_HLT);

    always_comb begin
`ifdef SEQ_EARLY_RESET_EN
        case (opcode)
            OP_LDA, OP_STA:                         last_step = T3;
            OP_ADD, OP_SUB:                         last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT:   last_step = T2;
            OP_HLT:                                 last_step = LAST_STEP;
            default:                                last_step = T1;
        endcase
`else
        last_step = LAST_STEP;
`endif
    end

    // HLT freezes the counter at T2; only reset releases it.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else if (!halted_q) begin
            if (hlt_exec) begin
                halted_q <= 1'b1;
            end else if (step_q == last_step) begin
                step_q <= T0;
            end else begin
                step_q <= step_q + 3'd1;
            end
        end
    end

    always_comb begin
        hlt  = 1'b0;
        mi_n = 1'b1;
        ri_n = 1'b1;
        ro_n = 1'b1;
        io_n = 1'b1;
        ii_n = 1'b1;
        ai_n = 1'b1;
        ao_n = 1'b1;
        eo_n = 1'b1;
        bi_n = 1'b1;
        oi_n = 1'b1;
        co_n = 1'b1;
        j_n  = 1'b1;
        fi_n = 1'b1;
        su   = 1'b0;
        ce   = 1'b0;
        if (!reset) begin
            if (halted_q) begin
                hlt = 1'b1;
            end else begin
                case (step_q)
                    T0: begin
                        co_n = 1'b0;
                        mi_n = 1'b0;
                    end
                    T1: begin
                        ro_n = 1'b0;
                        ii_n = 1'b0;
                        ce   = 1'b1;
                    end
                    T2: begin
                        case (opcode)
                            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                                io_n = 1'b0;
                                mi_n = 1'b0;
                            end
                            OP_LDI: begin
                                io_n = 1'b0;
                                ai_n = 1'b0;
                            end
                            OP_JMP: begin
                                io_n = 1'b0;
                                j_n  = 1'b0;
                            end
                            OP_JC: begin
                                io_n = !flags[0];
                                j_n  = !flags[0];
                            end
                            OP_JZ: begin
                                io_n = !flags[1];
                                j_n  = !flags[1];
                            end
                            OP_OUT: begin
                                ao_n = 1'b0;
                                oi_n = 1'b0;
                            end
                            OP_HLT:  hlt = 1'b1;
                            default: ;
                        endcase
                    end
                    T3: begin
                        case (opcode)
                            OP_LDA: begin
                                ro_n = 1'b0;
                                ai_n = 1'b0;
                            end
                            OP_ADD, OP_SUB: begin
                                ro_n = 1'b0;
                                bi_n = 1'b0;
                            end
                            OP_STA: begin
                                ao_n = 1'b0;
                                ri_n = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                    T4: begin
                        if (opcode == OP_ADD || opcode == OP_SUB) begin
                            eo_n = 1'b0;
                            ai_n = 1'b0;
                            fi_n = 1'b0;
                            su   = (opcode == OP_SUB);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Scoreboard bench for sap_control_sequencer: a text-table microprogram model predicts every cycle's outputs.
module tb_sap_control_sequencer;

    localparam int STEPS = 5;
`ifdef SEQ_EARLY_RESET_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] opcode;
    logic [1:0] flags;
    logic [2:0] step;
    logic       halted, hlt;
    logic       mi_n, ri_n, ro_n, io_n, ii_n, ai_n, ao_n, eo_n, bi_n, oi_n, co_n, j_n, fi_n;
    logic       su, ce;

    sap_control_sequencer #(.NUM_STEPS(STEPS)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .flags(flags),
        .step(step), .halted(halted), .hlt(hlt),
        .mi_n(mi_n), .ri_n(ri_n), .ro_n(ro_n), .io_n(io_n), .ii_n(ii_n),
        .ai_n(ai_n), .ao_n(ao_n), .eo_n(eo_n), .bi_n(bi_n), .oi_n(oi_n),
        .co_n(co_n), .j_n(j_n), .fi_n(fi_n), .su(su), .ce(ce)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  step;
        logic        halted;
        logic [15:0] ctrl;
        int          op;
        int          idx;
    } exp_t;

    exp_t  sb[$];
    bit    done = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;

    // Microprogram as text: prog[opcode][step] lists the asserted controls.
    string prog [16][8];
    int    last_tbl [16];
    int    m_step   = 0;
    bit    m_halted = 1'b0;
    int    push_idx = 0;

    // Asserted-sense bit positions of the control word.
    function automatic int name_bit(input string n);
        if (n == "hlt") return 15;
        if (n == "mi")  return 14;
        if (n == "ri")  return 13;
        if (n == "ro")  return 12;
        if (n == "io")  return 11;
        if (n == "ii")  return 10;
        if (n == "ai")  return 9;
        if (n == "ao")  return 8;
        if (n == "eo")  return 7;
        if (n == "bi")  return 6;
        if (n == "oi")  return 5;
        if (n == "co")  return 4;
        if (n == "j")   return 3;
        if (n == "fi")  return 2;
        if (n == "su")  return 1;
        return 0;
    endfunction

    function automatic logic [15:0] word_of(input string s);
        logic [15:0] w;
        int start;
        w = '0;
        start = 0;
        for (int i = 0; i <= s.len(); i++) begin
            if (i == s.len() || s[i] == 8'h20) begin
                if (i > start) w[name_bit(s.substr(start, i - 1))] = 1'b1;
                start = i + 1;
            end
        end
        return w;
    endfunction

    function automatic logic [15:0] micro(input int st, input int op, input logic [1:0] fl);
        if (st == 0) return word_of("co mi");
        if (st == 1) return word_of("ro ii ce");
        if (op == 7 && !fl[0]) return '0;
        if (op == 8 && !fl[1]) return '0;
        return word_of(prog[op][st]);
    endfunction

    task automatic cycle(input bit r, input int op, input logic [1:0] fl);
        exp_t e;
        int   last;
        reset  = r;
        opcode = 4'(op);
        flags  = fl;
        e.step   = 3'(m_step);
        e.halted = m_halted;
        e.op     = op;
        e.idx    = push_idx;
        if (r)             e.ctrl = '0;
        else if (m_halted) e.ctrl = word_of("hlt");
        else               e.ctrl = micro(m_step, op, fl);
        sb.push_back(e);
        push_idx++;
        if (r) begin
            m_step   = 0;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 2 && op == 15) begin
                m_halted = 1'b1;
            end else begin
                last   = EARLY ? last_tbl[op] : STEPS - 1;
                m_step = (m_step == last) ? 0 : m_step + 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input int op, input logic [1:0] fl, input int reset_at);
        int n;
        n = 0;
        do begin
            cycle(n == reset_at, op, fl);
            n++;
        end while (m_step != 0 && !m_halted && n < 16);
        if (m_halted) begin
            repeat (10) cycle(1'b0, op, fl);
            cycle(1'b1, op, fl);
        end
    endtask

    initial begin
        for (int o = 0; o < 16; o++) begin
            last_tbl[o] = 1;
            for (int s = 0; s < 8; s++) prog[o][s] = "";
        end
        prog[1][2]  = "io mi"; prog[1][3] = "ro ai";
        prog[2][2]  = "io mi"; prog[2][3] = "ro bi"; prog[2][4] = "eo ai fi";
        prog[3][2]  = "io mi"; prog[3][3] = "ro bi"; prog[3][4] = "eo ai fi su";
        prog[4][2]  = "io mi"; prog[4][3] = "ao ri";
        prog[5][2]  = "io ai";
        prog[6][2]  = "io j";
        prog[7][2]  = "io j";
        prog[8][2]  = "io j";
        prog[14][2] = "ao oi";
        prog[15][2] = "hlt";
        last_tbl[1] = 3; last_tbl[4] = 3;
        last_tbl[2] = 4; last_tbl[3] = 4;
        last_tbl[5] = 2; last_tbl[6] = 2; last_tbl[7] = 2; last_tbl[8] = 2; last_tbl[14] = 2;
        last_tbl[15] = STEPS - 1;

        reset  = 1'b1;
        opcode = 4'd0;
        flags  = 2'b00;
        @(posedge clk);
        #1;
        cycle(1'b1, 0, 2'b00);
        cycle(1'b1, 0, 2'b00);
        run_instr(0, 2'b00, -1);
        run_instr(0, 2'b00, -1);
        run_instr(3, 2'b00, -1);
        run_instr(5, 2'b00, -1);
        run_instr(2, 2'b11, -1);
        run_instr(8, 2'b00, -1);
        run_instr(8, 2'b10, -1);
        run_instr(7, 2'b01, -1);
        run_instr(7, 2'b10, -1);
        run_instr(1, 2'b00, 3);
        cycle(1'b1, 0, 2'b00);
        run_instr(4, 2'b00, -1);
        run_instr(14, 2'b00, -1);
        run_instr(11, 2'b00, -1);
        run_instr(15, 2'b00, -1);
        for (int k = 0; k < 250; k++) begin
            int op;
            int ra;
            op = $urandom_range(0, 15);
            ra = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(op, 2'($urandom_range(0, 3)), ra);
        end
        done = 1'b1;
    end

    initial begin
        exp_t        e;
        logic [15:0] act;
        int          cyc;
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                act = {hlt, ~mi_n, ~ri_n, ~ro_n, ~io_n, ~ii_n, ~ai_n, ~ao_n,
                       ~eo_n, ~bi_n, ~oi_n, ~co_n, ~j_n, ~fi_n, su, ce};
                n_checks++;
                if (step !== e.step) begin
                    n_errors++;
                    $display("FAIL step cycle=%0d op=%0d got=%0d want=%0d", e.idx, e.op, step, e.step);
                end
                n_checks++;
                if (halted !== e.halted) begin
                    n_errors++;
                    $display("FAIL halted cycle=%0d op=%0d got=%0b want=%0b", e.idx, e.op, halted, e.halted);
                end
                n_checks++;
                if (act !== e.ctrl) begin
                    n_errors++;
                    $display("FAIL ctrl cycle=%0d op=%0d got=%h want=%h", e.idx, e.op, act, e.ctrl);
                end
            end else if (done || cyc > 60000) begin
                if (!done) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL timeout got=%0d cycles want=stimulus complete", cyc);
                end
                $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
                $finish;
            end
        end
    end

endmodule
